// File: rtl/fd_reg_pkg.sv
// Shared constants and payload type for the F/D pipeline register.
// Optional fetch address check is enabled with macro FD_ADDR_CHECK_EN.
package fd_reg_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned EXC_W    = 5;

    localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
    localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;

    localparam logic [XLEN-1:0] IM_BASE = 32'h0000_3000;
    localparam logic [XLEN-1:0] IM_LAST = 32'h0000_6FFC;

    localparam logic [XLEN-1:0] DEF_RESET_PC   = 32'h0000_3000;
    localparam logic [XLEN-1:0] DEF_HANDLER_PC = 32'h0000_4180;

    // Contents of the D stage latch
    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  instr;
        logic [EXC_W-1:0] exccode;
        logic             bd;
        logic             valid;
    } d_payload_t;

    // True when a fetch from this address must raise AdEL (unsigned compare)
    function automatic logic fetch_addr_bad(input logic [XLEN-1:0] pc);
        return (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_LAST);
    endfunction

endpackage

// File: rtl/fd_reg_if.sv
// F-to-D stage signal bundle; master drives F side, slave is the D register.
interface fd_reg_if;
    import fd_reg_pkg::*;

    logic             stall;
    logic             req;
    logic             flush;
    logic [XLEN-1:0]  f_pc;
    logic [XLEN-1:0]  f_instr;
    logic             f_bd;
    logic [XLEN-1:0]  d_pc;
    logic [XLEN-1:0]  d_instr;
    logic [EXC_W-1:0] d_exccode;
    logic             d_bd;
    logic             d_valid;

    modport master (
        output stall, req, flush, f_pc, f_instr, f_bd,
        input  d_pc, d_instr, d_exccode, d_bd, d_valid
    );

    modport slave (
        input  stall, req, flush, f_pc, f_instr, f_bd,
        output d_pc, d_instr, d_exccode, d_bd, d_valid
    );
endinterface

// File: rtl/fd_reg_fetch_exc_check.sv
// Combinational fetch address check (AdEL); only built with FD_ADDR_CHECK_EN.
`ifdef FD_ADDR_CHECK_EN
module fetch_exc_check
    import fd_reg_pkg::*;
(
    input  logic [XLEN-1:0]  i_pc,
    output logic [EXC_W-1:0] o_code
);
    // Misaligned or outside instruction memory window faults
    always_comb begin
        o_code = EXC_NONE;
        if (fetch_addr_bad(i_pc)) begin
            o_code = EXC_ADEL;
        end
    end
endmodule
`endif

// File: rtl/fd_reg.sv
// F/D pipeline register with reset, exception flush, stall and squash.
// Macro FD_ADDR_CHECK_EN enables the fetch address (AdEL) check.
module fd_reg
    import fd_reg_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [XLEN-1:0] HANDLER_PC = DEF_HANDLER_PC
) (
    input  logic   clk,
    input  logic   reset,
    fd_reg_if.slave bus
);

    d_payload_t       r_d;
    logic [EXC_W-1:0] w_exc;
    logic             w_fault;

`ifdef FD_ADDR_CHECK_EN
    fetch_exc_check u_exc_check (
        .i_pc   (bus.f_pc),
        .o_code (w_exc)
    );
`else
    assign w_exc = EXC_NONE;
`endif

    assign w_fault = (w_exc != EXC_NONE);

    // Priority: reset > req > stall > flush > load
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_d.pc      <= RESET_PC;
            r_d.instr   <= '0;
            r_d.exccode <= EXC_NONE;
            r_d.bd      <= 1'b0;
            r_d.valid   <= 1'b0;
        end else if (bus.req) begin
            r_d.pc      <= HANDLER_PC;
            r_d.instr   <= '0;
            r_d.exccode <= EXC_NONE;
            r_d.bd      <= 1'b0;
            r_d.valid   <= 1'b0;
        end else if (bus.stall) begin
            r_d <= r_d;
        end else if (bus.flush) begin
            // Keep the PC so the bubble still carries a meaningful address
            r_d.pc      <= bus.f_pc;
            r_d.instr   <= '0;
            r_d.exccode <= EXC_NONE;
            r_d.bd      <= 1'b0;
            r_d.valid   <= 1'b0;
        end else begin
            r_d.pc      <= bus.f_pc;
            r_d.instr   <= w_fault ? '0 : bus.f_instr;
            r_d.exccode <= w_exc;
            r_d.bd      <= bus.f_bd;
            r_d.valid   <= 1'b1;
        end
    end

    assign bus.d_pc      = r_d.pc;
    assign bus.d_instr   = r_d.instr;
    assign bus.d_exccode = r_d.exccode;
    assign bus.d_bd      = r_d.bd;
    assign bus.d_valid   = r_d.valid;

endmodule

// File: tb/tb_fd_reg.sv
// Self-checking bench for fd_reg: behavioural model plus directed literal checks.
module tb_fd_reg;

    logic clk;
    logic reset;

    fd_reg_if bus ();

    fd_reg #(
        .RESET_PC   (32'h0000_3000),
        .HANDLER_PC (32'h0000_4180)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [4:0]  m_exc;
    logic        m_bd;
    logic        m_valid;

    function automatic logic [4:0] model_exc(input logic [31:0] pc);
`ifdef FD_ADDR_CHECK_EN
        if (pc % 4 != 0)        return 5'd4;
        if (pc < 32'h0000_3000) return 5'd4;
        if (pc > 32'h0000_6FFC) return 5'd4;
        return 5'd0;
`else
        return 5'd0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Advance the model from the current inputs, clock once, compare all outputs
    task automatic step();
        if (!reset) begin
            m_pc = 32'h3000; m_instr = 0; m_exc = 0; m_bd = 0; m_valid = 0;
        end else if (bus.req) begin
            m_pc = 32'h4180; m_instr = 0; m_exc = 0; m_bd = 0; m_valid = 0;
        end else if (bus.stall) begin
            // hold
        end else if (bus.flush) begin
            m_pc = bus.f_pc; m_instr = 0; m_exc = 0; m_bd = 0; m_valid = 0;
        end else begin
            m_exc   = model_exc(bus.f_pc);
            m_pc    = bus.f_pc;
            m_instr = (m_exc == 5'd0) ? bus.f_instr : 32'h0;
            m_bd    = bus.f_bd;
            m_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("model_pc",    bus.d_pc,                m_pc);
        chk("model_instr", bus.d_instr,             m_instr);
        chk("model_exc",   32'(bus.d_exccode),      32'(m_exc));
        chk("model_bd",    32'(bus.d_bd),           32'(m_bd));
        chk("model_valid", 32'(bus.d_valid),        32'(m_valid));
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] instr, input logic bd);
        bus.f_pc = pc; bus.f_instr = instr; bus.f_bd = bd;
    endtask

    initial begin
        reset = 1'b0;
        bus.stall = 0; bus.req = 0; bus.flush = 0;
        drive(32'h3000, 32'h3C01_0001, 1'b0);
        @(negedge clk);

        // Reset two cycles
        step(); step();
        chk("rst_pc",    bus.d_pc, 32'h3000);
        chk("rst_valid", 32'(bus.d_valid), 32'd0);
        chk("rst_instr", bus.d_instr, 32'h0);

        reset = 1'b1;
        step();
        chk("first_instr", bus.d_instr, 32'h3C01_0001);
        chk("first_valid", 32'(bus.d_valid), 32'd1);

        // Address boundaries and misalignment
        drive(32'h3002, 32'h1234_5678, 1'b1);
        step();
`ifdef FD_ADDR_CHECK_EN
        chk("misal_exc",   32'(bus.d_exccode), 32'd4);
        chk("misal_instr", bus.d_instr, 32'h0);
`else
        chk("misal_exc",   32'(bus.d_exccode), 32'd0);
        chk("misal_instr", bus.d_instr, 32'h1234_5678);
`endif
        chk("misal_pc", bus.d_pc, 32'h3002);
        chk("misal_bd", 32'(bus.d_bd), 32'd1);

        drive(32'h7000, 32'hAAAA_0001, 1'b0);
        step();
`ifdef FD_ADDR_CHECK_EN
        chk("hi_out_exc", 32'(bus.d_exccode), 32'd4);
`else
        chk("hi_out_exc", 32'(bus.d_exccode), 32'd0);
`endif
        drive(32'h6FFC, 32'hAAAA_0002, 1'b0);
        step();
        chk("hi_edge_exc",   32'(bus.d_exccode), 32'd0);
        chk("hi_edge_instr", bus.d_instr, 32'hAAAA_0002);
        drive(32'h2FFC, 32'hAAAA_0003, 1'b0); step();
        drive(32'h3000, 32'hAAAA_0004, 1'b0); step();
        chk("lo_edge_exc", 32'(bus.d_exccode), 32'd0);
        drive(32'hFFFF_3000, 32'hAAAA_0005, 1'b0); step();
        drive(32'h3001, 32'hAAAA_0006, 1'b0); step();
`ifndef FD_ADDR_CHECK_EN
        chk("nochk_exc",   32'(bus.d_exccode), 32'd0);
        chk("nochk_instr", bus.d_instr, 32'hAAAA_0006);
`endif

        // Stall holds for three cycles; flush with stall is ignored
        drive(32'h3004, 32'h8C22_0004, 1'b1);
        step();
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(32'h3100 + 32'(i * 4), $urandom, 1'(i));
            bus.flush = (i == 2);
            step();
            chk("stall_pc",    bus.d_pc, 32'h3004);
            chk("stall_instr", bus.d_instr, 32'h8C22_0004);
        end

        // req beats stall and flush
        bus.req = 1'b1; bus.flush = 1'b1;
        step();
        chk("req_pc",    bus.d_pc, 32'h4180);
        chk("req_instr", bus.d_instr, 32'h0);
        chk("req_valid", 32'(bus.d_valid), 32'd0);
        chk("req_bd",    32'(bus.d_bd), 32'd0);

        // Flush alone makes a bubble, keeps the PC
        bus.req = 1'b0; bus.stall = 1'b0; bus.flush = 1'b1;
        drive(32'h3010, 32'h0123_4567, 1'b1);
        step();
        chk("flush_pc",    bus.d_pc, 32'h3010);
        chk("flush_instr", bus.d_instr, 32'h0);
        chk("flush_bd",    32'(bus.d_bd), 32'd0);
        chk("flush_valid", 32'(bus.d_valid), 32'd0);
        bus.stall = 1'b1;
        drive(32'h3020, 32'h0000_1111, 1'b0);
        step();
        chk("flush_stall_pc", bus.d_pc, 32'h3010);
        bus.flush = 1'b0;

        // Reset overrides stall and req; next unstalled edge loads
        drive(32'h3040, 32'h2222_0000, 1'b0);
        reset = 1'b0; step();
        chk("rst_stall_pc", bus.d_pc, 32'h3000);
        bus.stall = 1'b0; bus.req = 1'b1; step();
        chk("rst_req_pc", bus.d_pc, 32'h3000);
        bus.req = 1'b0; reset = 1'b1; step();
        chk("post_rst_pc",    bus.d_pc, 32'h3040);
        chk("post_rst_valid", 32'(bus.d_valid), 32'd1);

        // Mixed control sweep against the model
        for (int i = 0; i < 40; i++) begin
            bus.stall = ($urandom_range(0, 3) == 0);
            bus.flush = ($urandom_range(0, 3) == 0);
            bus.req   = ($urandom_range(0, 7) == 0);
            reset     = ($urandom_range(0, 15) != 0);
            drive(32'h2FF0 + 32'($urandom_range(0, 32'h4020)), $urandom, 1'($urandom_range(0, 1)));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fd_reg.md
FD_REG -- requirements
Module: fd_reg

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000; d_pc value after reset.
REQ-002 Parameter HANDLER_PC, default 32'h0000_4180; d_pc value loaded on exception/interrupt flush.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  one clock; reset is synchronous and active-low.
REQ-005 stall  in  1  hazard-unit hold; D contents frozen.
REQ-006 req  in  1  exception/interrupt taken; flush D.
REQ-007 flush  in  1  squash fetched instruction (ERET/redirect); D becomes bubble.
REQ-008 f_pc  in  32  address of instruction in F.
REQ-009 f_instr  in  32  instruction word read from IM.
REQ-010 f_bd  in  1  F instruction sits in a branch delay slot.
REQ-011 d_pc  out  32  registered PC for D.
REQ-012 d_instr  out  32  registered instruction; 0 (nop) for bubbles and faulting fetches.
REQ-013 d_exccode  out  5  registered fetch exception code; 0 = none.
REQ-014 d_bd  out  1  registered delay-slot flag.
REQ-015 d_valid  out  1  D holds a real fetched instruction (not bubble).

Function
REQ-016 All outputs SHALL be registered; zero combinational path from inputs to outputs.
REQ-017 Update priority per edge SHALL be: reset low > req > stall > flush > normal load.
REQ-018 Normal load: d_pc=f_pc, d_instr=f_instr, d_bd=f_bd, d_valid=1, d_exccode=fetch check result; latency 1 cycle.
REQ-019 Fetch check SHALL flag AdEL (code 5'd4) when f_pc[1:0]!=0 or f_pc outside [32'h3000, 32'h6FFC].
REQ-020 On AdEL load: d_instr=0, d_exccode=4, d_pc=f_pc (exact faulting address kept for EPC), d_bd=f_bd, d_valid=1.
REQ-021 req high: d_pc=HANDLER_PC, d_instr=0, d_exccode=0, d_bd=0, d_valid=0, regardless of stall/flush.
REQ-022 stall high (req low): all outputs hold previous values; flush ignored that cycle.
REQ-023 flush high (req, stall low): d_instr=0, d_exccode=0, d_bd=0, d_valid=0, d_pc=f_pc (macro PC stays meaningful).
REQ-024 Boundaries 32'h3000 and 32'h6FFC SHALL be legal; 32'h2FFC and 32'h7000 SHALL fault.
REQ-025 Address compare SHALL be unsigned 32-bit; no wrap-around acceptance.

Reset
REQ-026 reset low at edge: d_pc=RESET_PC, d_instr=0, d_exccode=0, d_bd=0, d_valid=0.
REQ-027 reset mid-stall or mid-req SHALL override; first post-reset edge with stall low SHALL perform normal load.

Configuration
REQ-028 Macro FD_ADDR_CHECK_EN defined: REQ-019/020/024 fetch check active.
REQ-029 Macro FD_ADDR_CHECK_EN undefined: d_exccode constant 0, f_instr always loaded unmodified; all other behaviour identical.

Structure
REQ-030 Shared package SHALL hold: exception codes (EXC_NONE=0, EXC_ADEL=4), IM_BASE=32'h3000, IM_LAST=32'h6FFC, default RESET_PC/HANDLER_PC constants.
REQ-031 One combinational sub-module fetch_exc_check (f_pc in, 5-bit code out) SHALL implement REQ-019; excluded when macro undefined.

Verification
REQ-032 reset low 2 cycles then high, f_pc=32'h3000, f_instr=32'h3C01_0001 -> after reset d_pc=32'h3000, d_valid=0; next edge d_instr=32'h3C01_0001, d_valid=1.
REQ-033 f_pc=32'h3002 (macro on) -> d_exccode=4, d_instr=0, d_pc=32'h3002; f_pc=32'h7000 -> d_exccode=4; f_pc=32'h6FFC -> d_exccode=0.
REQ-034 Load 32'h3004/instr X, then stall=1 for 3 cycles with changing f_pc -> d_pc=32'h3004, d_instr=X held all 3 cycles.
REQ-035 stall=1, req=1, flush=1 same edge -> d_pc=32'h4180, d_instr=0, d_valid=0, d_bd=0.
REQ-036 flush=1, stall=0, f_pc=32'h3010, f_bd=1 -> d_pc=32'h3010, d_instr=0, d_bd=0, d_valid=0; flush=1 with stall=1 -> hold.
REQ-037 Macro undefined, f_pc=32'h3001 -> d_exccode=0, d_instr=f_instr.
